// File: rtl/block_stream_arbiter_pkg.sv
// Shared types for the block stream arbiter: FSM states, requester identity,
// and the default block size.
package block_stream_arbiter_pkg;

  localparam int unsigned BYTES_PER_BLOCK_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } state_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

endpackage

// File: rtl/block_stream_arbiter_byte_serializer.sv
// Paced byte emitter: holds one captured block and releases one byte every
// BYTE_PERIOD cycles while running, index 0 first.
module block_byte_serializer
  import block_stream_arbiter_pkg::*;
#(
  parameter int unsigned BYTES_PER_BLOCK = BYTES_PER_BLOCK_DEF,
  parameter int unsigned BYTE_PERIOD     = 4
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            i_load,
  input  logic [BYTES_PER_BLOCK-1:0][7:0] i_block,
  input  logic                            i_run,
  output logic [7:0]                      o_byte,
  output logic                            o_byte_valid,
  output logic                            o_last
);

  localparam int unsigned IDX_SEL_W = (BYTES_PER_BLOCK > 1) ? $clog2(BYTES_PER_BLOCK) : 1;
  localparam logic [7:0]  PACE_LAST = 8'(BYTE_PERIOD - 1);
  localparam logic [4:0]  IDX_LAST  = 5'(BYTES_PER_BLOCK - 1);

  logic [BYTES_PER_BLOCK-1:0][7:0] r_buf;
  logic [4:0]                      r_idx;
  logic [7:0]                      r_pace;
  logic [7:0]                      r_hold;
  logic                            w_emit;
  logic [7:0]                      w_cur;

  always_comb begin
    w_emit = i_run && (r_pace == PACE_LAST);
    w_cur  = r_buf[r_idx[IDX_SEL_W-1:0]];
  end

  always_ff @(posedge clk_in) begin
    if (i_load) r_buf <= i_block;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_idx  <= '0;
      r_pace <= '0;
      r_hold <= '0;
    end else if (i_load) begin
      r_idx  <= '0;
      r_pace <= '0;
    end else if (i_run) begin
      if (w_emit) begin
        r_pace <= '0;
        r_idx  <= r_idx + 5'd1;
        r_hold <= w_cur;
      end else begin
        r_pace <= r_pace + 8'd1;
      end
    end
  end

  // The emitted byte is presented in the same cycle the pace counter tops out;
  // between emissions the last byte is held.
  assign o_byte       = w_emit ? w_cur : r_hold;
  assign o_byte_valid = w_emit;
  assign o_last       = w_emit && (r_idx == IDX_LAST);

endmodule

// File: rtl/block_stream_arbiter.sv
// Round-robin arbiter between two block requesters; the granted block is
// streamed out byte by byte by block_byte_serializer.
module block_stream_arbiter
  import block_stream_arbiter_pkg::*;
#(
  parameter int unsigned BYTES_PER_BLOCK = BYTES_PER_BLOCK_DEF,
  parameter int unsigned BYTE_PERIOD     = 4
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            a_valid_in,
  input  logic [BYTES_PER_BLOCK-1:0][7:0] a_block_in,
  output logic                            a_ready_out,
  input  logic                            b_valid_in,
  input  logic [BYTES_PER_BLOCK-1:0][7:0] b_block_in,
  output logic                            b_ready_out,
  input  logic                            abort_in,
  output logic [7:0]                      byte_out,
  output logic                            byte_valid_out,
  output logic                            src_out,
  output logic                            done_out,
  output logic                            busy_out
);

  state_t r_state;
  state_t w_next;
  src_t   r_ptr;
  src_t   r_src;

  logic                            w_pick_b;
  logic                            w_take;
  logic                            w_run;
  logic                            w_last;
  logic [BYTES_PER_BLOCK-1:0][7:0] w_block;

  always_comb begin
    w_pick_b = b_valid_in && (!a_valid_in || (r_ptr == SRC_B));
    w_take   = (r_state == ST_IDLE) && !rst_in && (a_valid_in || b_valid_in);
    w_block  = w_pick_b ? b_block_in : a_block_in;
    w_run    = (r_state == ST_STREAM);
    w_next   = r_state;
    case (r_state)
      ST_IDLE:   if (w_take) w_next = ST_STREAM;
      // abort on the final byte still lets it out but skips DONE
      ST_STREAM: begin
        if (w_last)        w_next = abort_in ? ST_IDLE : ST_DONE;
        else if (abort_in) w_next = ST_IDLE;
      end
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
      r_ptr   <= SRC_A;
      r_src   <= SRC_A;
    end else begin
      r_state <= w_next;
      if (w_take) r_src <= w_pick_b ? SRC_B : SRC_A;
      if (w_run && w_last && !abort_in) r_ptr <= (r_src == SRC_A) ? SRC_B : SRC_A;
    end
  end

  block_byte_serializer #(
    .BYTES_PER_BLOCK (BYTES_PER_BLOCK),
    .BYTE_PERIOD     (BYTE_PERIOD)
  ) u_ser (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .i_load       (w_take),
    .i_block      (w_block),
    .i_run        (w_run),
    .o_byte       (byte_out),
    .o_byte_valid (byte_valid_out),
    .o_last       (w_last)
  );

  assign a_ready_out = w_take && !w_pick_b;
  assign b_ready_out = w_take && w_pick_b;
  assign src_out     = r_src;
  assign done_out    = (r_state == ST_DONE);
  assign busy_out    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_block_stream_arbiter.sv
// Directed bench: one arbiter paced at 4 cycles/byte and one at 1 cycle/byte.
module tb_block_stream_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             a_valid [2];
  logic             b_valid [2];
  logic             abort   [2];
  logic             a_ready [2];
  logic             b_ready [2];
  logic             bvalid  [2];
  logic             src     [2];
  logic             done    [2];
  logic             busy    [2];
  logic [7:0]       bout    [2];
  logic [7:0]       held    [2];
  logic [15:0][7:0] a_blk;
  logic [15:0][7:0] b_blk;

  int n_chk = 0;
  int n_err = 0;

  block_stream_arbiter #(.BYTES_PER_BLOCK(16), .BYTE_PERIOD(4)) u_p4 (
    .clk_in(clk), .rst_in(rst),
    .a_valid_in(a_valid[0]), .a_block_in(a_blk), .a_ready_out(a_ready[0]),
    .b_valid_in(b_valid[0]), .b_block_in(b_blk), .b_ready_out(b_ready[0]),
    .abort_in(abort[0]), .byte_out(bout[0]), .byte_valid_out(bvalid[0]),
    .src_out(src[0]), .done_out(done[0]), .busy_out(busy[0])
  );

  block_stream_arbiter #(.BYTES_PER_BLOCK(16), .BYTE_PERIOD(1)) u_p1 (
    .clk_in(clk), .rst_in(rst),
    .a_valid_in(a_valid[1]), .a_block_in(a_blk), .a_ready_out(a_ready[1]),
    .b_valid_in(b_valid[1]), .b_block_in(b_blk), .b_ready_out(b_ready[1]),
    .abort_in(abort[1]), .byte_out(bout[1]), .byte_valid_out(bvalid[1]),
    .src_out(src[1]), .done_out(done[1]), .busy_out(busy[1])
  );

  typedef struct {
    logic av;
    logic bv;
    logic eb;        // 1: B expected to win
    int   abort_c;   // cycle after handshake carrying abort (0 = none)
    int   rst_c;     // cycle after handshake carrying reset (0 = none)
    logic keep;      // keep valids high through the block
    int   exp_wait;  // cycles from call until handshake
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input int d);
    chk("rst_byte_out", bout[d], 0);
    chk("rst_byte_valid", bvalid[d], 0);
    chk("rst_src", src[d], 0);
    chk("rst_done", done[d], 0);
    chk("rst_busy", busy[d], 0);
    chk("rst_ready", a_ready[d] | b_ready[d], 0);
  endtask

  task automatic run_block(input int d, input int p, input logic av, input logic bv,
                           input logic eb, input int abort_c, input int rst_c,
                           input logic keep, input int exp_wait);
    int         wait_n;
    bit         found;
    int         last;
    int         k;
    logic       exp_v;
    logic [7:0] exp_byte;
    a_valid[d] = av;
    b_valid[d] = bv;
    wait_n = 0;
    found  = 1'b0;
    while (!found && wait_n < 200) begin
      #1;
      if (a_ready[d] || b_ready[d]) found = 1'b1;
      else begin
        wait_n++;
        @(negedge clk);
      end
    end
    chk("handshake_seen", int'(found), 1);
    if (!found) return;
    chk("a_ready_grant", a_ready[d], int'(!eb));
    chk("b_ready_grant", b_ready[d], int'(eb));
    chk("handshake_wait", wait_n, exp_wait);
    last = 16 * p + 1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      #1;
      if (c == 1 && !keep) begin
        a_valid[d] = 1'b0;
        b_valid[d] = 1'b0;
      end
      if (abort_c != 0 && c == abort_c + 1) begin
        abort[d] = 1'b0;
        chk("abort_busy", busy[d], 0);
        chk("abort_byte_valid", bvalid[d], 0);
        chk("abort_done", done[d], 0);
        @(negedge clk);
        #1;
        chk("abort_no_more_bytes", bvalid[d], 0);
        chk("abort_stay_idle", busy[d], 0);
        break;
      end
      if (rst_c != 0 && c == rst_c + 1) begin
        chk_idle_outputs(d);
        a_valid[d] = 1'b1;
        b_valid[d] = 1'b1;
        #1;
        chk("ready_in_reset", a_ready[d] | b_ready[d], 0);
        break;
      end
      exp_v = (c % p == 0) && (c <= 16 * p);
      k     = c / p - 1;
      chk("byte_valid", bvalid[d], int'(exp_v));
      if (exp_v) begin
        exp_byte = eb ? (8'h80 | 8'(k)) : 8'(k);
        chk("byte_value", bout[d], exp_byte);
        held[d] = exp_byte;
      end else begin
        chk("byte_hold", bout[d], held[d]);
      end
      chk("done", done[d], int'(c == last));
      chk("busy", busy[d], 1);
      chk("src", src[d], int'(eb));
      chk("ready_low", a_ready[d] | b_ready[d], 0);
      if (c == abort_c) abort[d] = 1'b1;
      if (c == rst_c) rst = 1'b1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          av    bv    eb    abort rst keep  wait
    tbl[0] = '{1'b1, 1'b0, 1'b0, 0,    0,  1'b0, 0};  // A alone, ptr -> B
    tbl[1] = '{1'b1, 1'b1, 1'b1, 0,    0,  1'b1, 1};  // contention: B, ptr -> A
    tbl[2] = '{1'b1, 1'b1, 1'b0, 0,    0,  1'b1, 1};  // A, ptr -> B
    tbl[3] = '{1'b1, 1'b1, 1'b1, 0,    0,  1'b1, 1};  // B, ptr -> A
    tbl[4] = '{1'b1, 1'b1, 1'b0, 0,    0,  1'b0, 1};  // A, ptr -> B
    tbl[5] = '{1'b1, 1'b1, 1'b1, 25,   0,  1'b0, 1};  // B aborted after byte 5
    tbl[6] = '{1'b1, 1'b1, 1'b1, 0,    0,  1'b0, 0};  // ptr unchanged: B, ptr -> A
    tbl[7] = '{1'b1, 1'b0, 1'b0, 64,   0,  1'b0, 1};  // abort on byte 15
    tbl[8] = '{1'b1, 1'b0, 1'b0, 0,    0,  1'b0, 0};  // A, ptr -> B
    tbl[9] = '{1'b0, 1'b1, 1'b1, 0,    40, 1'b0, 1};  // reset at byte 9

    for (int unsigned i = 0; i < 16; i++) begin
      a_blk[i] = 8'(i);
      b_blk[i] = 8'h80 | 8'(i);
    end
    for (int d = 0; d < 2; d++) begin
      a_valid[d] = 1'b1;
      b_valid[d] = 1'b1;
      abort[d]   = 1'b0;
      held[d]    = 8'h00;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk_idle_outputs(d);
    for (int d = 0; d < 2; d++) begin
      a_valid[d] = 1'b0;
      b_valid[d] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_block(0, 4, tbl[i].av, tbl[i].bv, tbl[i].eb, tbl[i].abort_c,
                tbl[i].rst_c, tbl[i].keep, tbl[i].exp_wait);

    // still in reset with both requesters valid: nothing granted
    @(negedge clk);
    #1;
    chk_idle_outputs(0);
    rst = 1'b0;
    held[0] = 8'h00;
    held[1] = 8'h00;
    // pointer was B before reset; reset returns it to A
    run_block(0, 4, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0);

    // single-cycle pacing: back-to-back bytes, next handshake right after DONE
    run_block(1, 1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 0);
    run_block(1, 1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/block_stream_arbiter.md
BLOCK_STREAM_ARBITER -- requirements
Module: block_stream_arbiter

Interface
REQ-001 SHALL have parameter BYTES_PER_BLOCK, default 16, number of bytes per block.
REQ-002 SHALL have parameter BYTE_PERIOD, default 4, clock cycles between emitted bytes (legal range 1..255).
REQ-003 SHALL have port clk_in, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_in, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port a_valid_in, input, 1, requester A has a block pending.
REQ-006 SHALL have port a_block_in, input, [15:0][7:0], requester A block.
REQ-007 SHALL have port a_ready_out, output, 1, A block accepted this cycle.
REQ-008 SHALL have ports b_valid_in, b_block_in and b_ready_out, identical to REQ-005..007, for requester B.
REQ-009 SHALL have port abort_in, input, 1, cancels the block in flight.
REQ-010 SHALL have port byte_out, output, 8, streamed byte.
REQ-011 SHALL have port byte_valid_out, output, 1, byte_out valid this cycle.
REQ-012 SHALL have port src_out, output, 1, owner of the current block (0=A, 1=B).
REQ-013 SHALL have port done_out, output, 1, one-cycle pulse after the last byte.
REQ-014 SHALL have port busy_out, output, 1, high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, STREAM and DONE.
REQ-016 IDLE, at least one valid_in high: SHALL grant one requester, pulse its ready_out in that same cycle (combinational from state and valids), capture its block and source, clear the byte index and pace counter, and go to STREAM.
REQ-017 Arbitration SHALL be round-robin with a 1-bit priority pointer (reset value A); when both are valid, the pointer side wins; when only one is valid, it wins regardless of the pointer.
REQ-018 The pointer SHALL flip to the side opposite the served source on entry to DONE only.
REQ-019 STREAM: the pace counter SHALL count 0..BYTE_PERIOD-1; when it equals BYTE_PERIOD-1, the block SHALL drive byte_out = buffer[index] and byte_valid_out=1 for exactly one cycle, and the index SHALL increment.
REQ-020 Byte order SHALL be index 0 first (a_block_in[0] is the first byte).
REQ-021 Latency: with the handshake on edge T, byte k SHALL be valid in cycle T+(k+1)*BYTE_PERIOD.
REQ-022 After byte BYTES_PER_BLOCK-1 is emitted, the FSM SHALL go to DONE; DONE SHALL assert done_out for one cycle, then return to IDLE.
REQ-023 A new grant SHALL NOT occur in DONE; the earliest next handshake is the cycle after DONE.
REQ-024 abort_in high in STREAM SHALL force IDLE on the next edge, with no further bytes, no done_out and no pointer change; abort_in in IDLE or DONE SHALL be ignored.
REQ-025 abort_in coinciding with the last byte SHALL let that byte emit, then go to IDLE with no done_out.
REQ-026 Requester inputs SHALL be ignored outside IDLE; ready_out SHALL be low outside IDLE.
REQ-027 byte_out SHALL hold its last value when byte_valid_out is low, and src_out SHALL hold until the next grant.
REQ-028 The index SHALL be 5 bits wide and the pace counter 8 bits wide; neither SHALL wrap inside a block.

Reset
REQ-029 rst_in high SHALL, on the next edge and from any state (including mid-stream), set state=IDLE, index=0, pace=0, pointer=A, byte_out=0, byte_valid_out=0, src_out=0, done_out=0 and busy_out=0.
REQ-030 While rst_in is high, ready_out SHALL be low.

Structure
REQ-031 A shared package SHALL hold the state enum, the source enum (SRC_A, SRC_B) and the BYTES_PER_BLOCK default.
REQ-032 The paced byte emitter (buffer, index, pace counter, byte outputs) SHALL be a sub-module named block_byte_serializer; the arbiter and FSM stay in the top module.

Verification
REQ-033 A only, block bytes 0x00..0x0F, BYTE_PERIOD=4 -> a_ready_out for 1 cycle; bytes 0x00..0x0F at cycles T+4, T+8 .. T+64; src_out=0; done_out at T+65.
REQ-034 A and B valid together, continuously -> served in order A, B, A, B; each ready_out pulses once per block; src_out alternates.
REQ-035 abort_in after byte 5 of a B block -> no bytes 6..15, no done_out, busy_out low next cycle, next contention won by B.
REQ-036 rst_in asserted at byte 9 -> all outputs 0 next cycle; after reset release with A and B valid, A wins.
REQ-037 BYTE_PERIOD=1 -> 16 consecutive byte_valid_out cycles, done_out in the following cycle, next handshake one cycle later.
REQ-038 abort_in on the byte-15 cycle -> byte 15 emitted, no done_out, state IDLE.
